sync_fifo_mc_top: RTL and testbench

- Single-clock, multi-channel FIFO: 2^ch_width independent logical FIFOs share one simple dual-port RAM.
- The channel number forms the upper address bits of the RAM.
- One write port and one read port, each with its own channel select, so any channel can be written and any channel read in the same cycle.
- Used where several low-rate streams in one clock domain need buffering without one RAM per stream.

---
 rtl/sync_fifo_mc_top.sv | 95 +++++++++
 tb/tb_sync_fifo_mc_top.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_mc_top.sv
// sync_fifo_mc_top: single-clock multi-channel FIFO.
// 2^ch_width logical FIFOs share one simple dual-port RAM; the channel number
// is the upper RAM address field. One write port and one read port, each with
// its own channel select.
// Optional feature: define SYNC_FIFO_MC_FILL_LEVEL_EN to add the per-channel
// fill-level output port "fill".
module sync_fifo_mc_top #(
  parameter int data_width = 18,
  parameter int addr_width = 4,
  parameter int ch_width   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [data_width-1:0]             d,
  input  logic                              wr,
  input  logic [ch_width-1:0]               wr_ch,
  input  logic                              rd,
  input  logic [ch_width-1:0]               rd_ch,
  output logic [data_width-1:0]             q,
  output logic                              q_valid,
  output logic [(1<<ch_width)-1:0]          fifo_full,
  output logic [(1<<ch_width)-1:0]          fifo_empty,
  output logic                              wr_err,
  output logic                              rd_err
`ifdef SYNC_FIFO_MC_FILL_LEVEL_EN
  ,
  output logic [(1<<ch_width)*(addr_width+1)-1:0] fill
`endif
);

  localparam int channels  = 1 << ch_width;
  localparam int ram_depth = 1 << (ch_width + addr_width);

  // Binary pointers, one extra MSB as the wrap bit to tell full from empty.
  logic [addr_width:0]          wptr [channels];
  logic [addr_width:0]          rptr [channels];
  logic [data_width-1:0]        mem  [ram_depth];

  logic                         wr_ok;
  logic                         rd_ok;
  logic [ch_width+addr_width-1:0] waddr;
  logic [ch_width+addr_width-1:0] raddr;

  // Per-channel flags (and optional fill level) straight from the registered pointers.
  for (genvar i = 0; i < channels; i++) begin : g_flags
    assign fifo_empty[i] = (wptr[i] == rptr[i]);
    assign fifo_full[i]  = (wptr[i][addr_width] != rptr[i][addr_width]) &&
                           (wptr[i][addr_width-1:0] == rptr[i][addr_width-1:0]);
`ifdef SYNC_FIFO_MC_FILL_LEVEL_EN
    assign fill[i*(addr_width+1) +: (addr_width+1)] = wptr[i] - rptr[i];
`endif
  end

  // Acceptance is judged on the pre-edge flags, so a concurrent read never
  // frees space for a write and a concurrent write never feeds a read.
  assign wr_ok = wr && !fifo_full[wr_ch];
  assign rd_ok = rd && !fifo_empty[rd_ch];
  assign waddr = {wr_ch, wptr[wr_ch][addr_width-1:0]};
  assign raddr = {rd_ch, rptr[rd_ch][addr_width-1:0]};

  // Pointer advance on accepted transfers; reset drops all queued data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < channels; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      if (wr_ok) wptr[wr_ch] <= wptr[wr_ch] + 1'b1;
      if (rd_ok) rptr[rd_ch] <= rptr[rd_ch] + 1'b1;
    end
  end

  // Shared storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[waddr] <= d;
  end

  // ---- read stage boundary: registered data, valid and error pulses ----
  // Read data register holds its value when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
      wr_err  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      q_valid <= rd_ok;
      wr_err  <= wr && fifo_full[wr_ch];
      rd_err  <= rd && fifo_empty[rd_ch];
      if (rd_ok) q <= mem[raddr];
    end
  end

endmodule

// File: tb/tb_sync_fifo_mc_top.sv
// Testbench for sync_fifo_mc_top: per-scenario tasks driving a queue-based
// reference model; build with +define+SYNC_FIFO_MC_FILL_LEVEL_EN to also
// check the fill output.
module tb_sync_fifo_mc_top;
  localparam int DW = 18, AW = 4, CW = 2, NCH = 4, DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] d;
  logic          wr, rd;
  logic [CW-1:0] wr_ch, rd_ch;
  logic [DW-1:0] q;
  logic          q_valid;
  logic [NCH-1:0] fifo_full, fifo_empty;
  logic          wr_err, rd_err;
`ifdef SYNC_FIFO_MC_FILL_LEVEL_EN
  logic [NCH*(AW+1)-1:0] fill;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per channel plus expected registered outputs.
  logic [DW-1:0] mq [NCH][$];
  logic [DW-1:0] exp_q;
  logic          exp_qv, exp_werr, exp_rerr;

  always #5 clk = ~clk;

  sync_fifo_mc_top #(.data_width(DW), .addr_width(AW), .ch_width(CW)) dut (
    .clk(clk), .rst(rst), .d(d), .wr(wr), .wr_ch(wr_ch), .rd(rd), .rd_ch(rd_ch),
    .q(q), .q_valid(q_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .wr_err(wr_err), .rd_err(rd_err)
`ifdef SYNC_FIFO_MC_FILL_LEVEL_EN
    , .fill(fill)
`endif
  );

  function automatic logic [NCH-1:0] m_empty();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (mq[i].size() == 0);
    return v;
  endfunction

  function automatic logic [NCH-1:0] m_full();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (mq[i].size() == DEPTH);
    return v;
  endfunction

  function automatic logic [NCH*(AW+1)-1:0] m_fill();
    logic [NCH*(AW+1)-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*(AW+1) +: (AW+1)] = mq[i].size();
    return v;
  endfunction

  // Drive one cycle of requests, advance the model, return at edge+1.
  task automatic cycle(input logic w, input int wc, input logic [DW-1:0] wd,
                       input logic r, input int rc);
    bit wok, rok;
    wr = w; wr_ch = wc[CW-1:0]; d = wd; rd = r; rd_ch = rc[CW-1:0];
    wok = w && (mq[wc].size() < DEPTH);
    rok = r && (mq[rc].size() > 0);
    exp_werr = w && !wok;
    exp_rerr = r && !rok;
    exp_qv   = rok;
    if (rok) exp_q = mq[rc].pop_front();
    if (wok) mq[wc].push_back(wd);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) mq[i].delete();
    exp_q = '0; exp_qv = 1'b0; exp_werr = 1'b0; exp_rerr = 1'b0;
  endtask

  task automatic test_reset();
    wr = 0; rd = 0; d = '0; wr_ch = '0; rd_ch = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    cycle(0, 0, '0, 0, 0);
    total++; if (fifo_empty !== 4'b1111) begin bad++; $display("FAIL reset_empty got=%b want=1111", fifo_empty); end
    total++; if (fifo_full !== 4'b0000) begin bad++; $display("FAIL reset_full got=%b want=0000", fifo_full); end
    total++; if (q_valid !== 1'b0 || q !== '0) begin bad++; $display("FAIL reset_q got=%b/%h want=0/0", q_valid, q); end
    total++; if (wr_err !== 1'b0 || rd_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b want=00", wr_err, rd_err); end
`ifdef SYNC_FIFO_MC_FILL_LEVEL_EN
    total++; if (fill !== '0) begin bad++; $display("FAIL reset_fill got=%h want=0", fill); end
`endif
  endtask

  task automatic test_fill_drain_ch2();
    for (int k = 1; k <= DEPTH; k++) begin
      cycle(1, 2, DW'(k), 0, 0);
      total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL ch2_wr_err k=%0d got=%b want=0", k, wr_err); end
    end
    total++; if (fifo_full !== 4'b0100) begin bad++; $display("FAIL ch2_full got=%b want=0100", fifo_full); end
    cycle(1, 2, 18'h3FFFF, 0, 0);
    total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL ch2_overflow_err got=%b want=1", wr_err); end
    cycle(0, 0, '0, 0, 0);
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL ch2_err_pulse got=%b want=0", wr_err); end
    total++; if (fifo_full !== 4'b0100) begin bad++; $display("FAIL ch2_full_hold got=%b want=0100", fifo_full); end
    for (int k = 1; k <= DEPTH; k++) begin
      cycle(0, 0, '0, 1, 2);
      total++; if (q_valid !== 1'b1 || q !== DW'(k)) begin bad++; $display("FAIL ch2_read k=%0d got=%b/%h want=1/%h", k, q_valid, q, DW'(k)); end
    end
    total++; if (fifo_empty !== 4'b1111) begin bad++; $display("FAIL ch2_empty_end got=%b want=1111", fifo_empty); end
  endtask

  task automatic test_interleave();
    for (int k = 0; k < 8; k++) begin
      cycle(1, 0, DW'(32'h0A000 + k), 0, 0);
      cycle(1, 3, DW'(32'h0B000 + k), 0, 0);
    end
    total++; if (fifo_empty !== 4'b0110) begin bad++; $display("FAIL inter_empty got=%b want=0110", fifo_empty); end
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, '0, 1, 3);
      total++; if (q_valid !== 1'b1 || q !== DW'(32'h0B000 + k)) begin bad++; $display("FAIL inter_ch3 k=%0d got=%h want=%h", k, q, DW'(32'h0B000 + k)); end
    end
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, '0, 1, 0);
      total++; if (q_valid !== 1'b1 || q !== DW'(32'h0A000 + k)) begin bad++; $display("FAIL inter_ch0 k=%0d got=%h want=%h", k, q, DW'(32'h0A000 + k)); end
    end
  endtask

  task automatic test_read_empty_with_write();
    logic [DW-1:0] w;
    logic [DW-1:0] q_before;
    w = DW'($urandom);
    q_before = q;
    cycle(1, 1, w, 1, 1);
    total++; if (rd_err !== 1'b1 || q_valid !== 1'b0) begin bad++; $display("FAIL rdempty_err got=%b/%b want=1/0", rd_err, q_valid); end
    total++; if (q !== q_before) begin bad++; $display("FAIL rdempty_qhold got=%h want=%h", q, q_before); end
    cycle(0, 0, '0, 1, 1);
    total++; if (q_valid !== 1'b1 || q !== w || rd_err !== 1'b0) begin bad++; $display("FAIL rdempty_next got=%b/%h want=1/%h", q_valid, q, w); end
  endtask

  task automatic test_full_simul();
    logic [DW-1:0] first;
    first = DW'($urandom);
    cycle(1, 0, first, 0, 0);
    for (int k = 1; k < DEPTH; k++) cycle(1, 0, DW'($urandom), 0, 0);
    total++; if (fifo_full[0] !== 1'b1) begin bad++; $display("FAIL fullrw_pre got=%b want=1", fifo_full[0]); end
    cycle(1, 0, DW'($urandom), 1, 0);
    total++; if (wr_err !== 1'b1 || rd_err !== 1'b0) begin bad++; $display("FAIL fullrw_err got=%b%b want=10", wr_err, rd_err); end
    total++; if (q_valid !== 1'b1 || q !== first) begin bad++; $display("FAIL fullrw_q got=%b/%h want=1/%h", q_valid, q, first); end
    total++; if (fifo_full[0] !== 1'b0 || fifo_empty[0] !== 1'b0) begin bad++; $display("FAIL fullrw_flags got=%b%b want=00", fifo_full[0], fifo_empty[0]); end
`ifdef SYNC_FIFO_MC_FILL_LEVEL_EN
    total++; if (fill[0 +: AW+1] !== 5'd15) begin bad++; $display("FAIL fullrw_fill got=%0d want=15", fill[0 +: AW+1]); end
`endif
    while (mq[0].size() > 0) begin
      cycle(0, 0, '0, 1, 0);
      total++; if (q_valid !== 1'b1 || q !== exp_q) begin bad++; $display("FAIL fullrw_drain got=%h want=%h", q, exp_q); end
    end
  endtask

  task automatic test_wrap_and_reset();
    for (int k = 0; k < 3; k++) cycle(1, 1, DW'($urandom), 0, 0);
    for (int k = 0; k < 40; k++) begin
      cycle(1, 1, DW'($urandom), 1, 1);
      total++; if (q_valid !== 1'b1 || q !== exp_q) begin bad++; $display("FAIL wrap_q k=%0d got=%h want=%h", k, q, exp_q); end
      total++; if (fifo_empty !== m_empty() || fifo_full !== m_full()) begin bad++; $display("FAIL wrap_flags k=%0d got=%b/%b want=%b/%b", k, fifo_empty, fifo_full, m_empty(), m_full()); end
    end
`ifdef SYNC_FIFO_MC_FILL_LEVEL_EN
    total++; if (fill !== m_fill()) begin bad++; $display("FAIL wrap_fill got=%h want=%h", fill, m_fill()); end
`endif
    // Reset asserted between edges must clear flags without a clock.
    wr = 1'b1; wr_ch = 2'd3; d = DW'($urandom);
    #2 rst = 1'b1;
    #1;
    model_clear();
    total++; if (fifo_empty !== 4'b1111 || fifo_full !== 4'b0000) begin bad++; $display("FAIL midrst_flags got=%b/%b want=1111/0000", fifo_empty, fifo_full); end
    total++; if (q_valid !== 1'b0 || q !== '0) begin bad++; $display("FAIL midrst_q got=%b/%h want=0/0", q_valid, q); end
    @(posedge clk); #1;
    wr = 1'b0;
    rst = 1'b0;
    cycle(0, 0, '0, 1, 1);
    total++; if (rd_err !== 1'b1 || q_valid !== 1'b0) begin bad++; $display("FAIL midrst_discard got=%b/%b want=1/0", rd_err, q_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic w, r;
      w = (n < 300) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
      r = (n < 300) ? ($urandom_range(1, 0) != 0) : ($urandom_range(3, 0) != 0);
      cycle(w, $urandom_range(NCH-1, 0), DW'($urandom), r, $urandom_range(NCH-1, 0));
      total++; if (q_valid !== exp_qv || q !== exp_q) begin bad++; $display("FAIL rand_q n=%0d got=%b/%h want=%b/%h", n, q_valid, q, exp_qv, exp_q); end
      total++; if (wr_err !== exp_werr || rd_err !== exp_rerr) begin bad++; $display("FAIL rand_err n=%0d got=%b%b want=%b%b", n, wr_err, rd_err, exp_werr, exp_rerr); end
      total++; if (fifo_empty !== m_empty() || fifo_full !== m_full()) begin bad++; $display("FAIL rand_flags n=%0d got=%b/%b want=%b/%b", n, fifo_empty, fifo_full, m_empty(), m_full()); end
`ifdef SYNC_FIFO_MC_FILL_LEVEL_EN
      total++; if (fill !== m_fill()) begin bad++; $display("FAIL rand_fill n=%0d got=%h want=%h", n, fill, m_fill()); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain_ch2();
    test_interleave();
    test_read_empty_with_write();
    test_full_simul();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
